// File: rtl/bw_mult_pkg.sv
// Shared types and helpers for the sequential Baugh-Wooley multiplier.
package bw_mult_pkg;

    // Widest operand the multiplier supports; sizes the constant-term helper.
    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Baugh-Wooley correction constant: in signed mode a 1 at weight WIDTH
    // and a 1 at weight 2*WIDTH-1 fold the sign-bit complements back in.
    // Returned at full MaxWidth span; callers keep the low 2*width bits.
    function automatic logic [2*MaxWidth-1:0] const_term(input int unsigned width,
                                                         input logic sgn);
        logic [2*MaxWidth-1:0] term;
        term = '0;
        if (sgn) begin
            term[width]         = 1'b1;
            term[2*width - 1]   = 1'b1;
        end
        return term;
    endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One Baugh-Wooley partial-product row, unshifted. The parent places it at
// weight i by shifting with the row index.
module bw_pp_row #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_bit_i,
    input  logic             sgn_i,
    input  logic             last_i,
    output logic [WIDTH-1:0] row_o
);

    // Plain AND row, then complement the sign-related terms in signed mode:
    // only the top bit on ordinary rows, every bit except the top on the last.
    always_comb begin
        row_o = a_i & {WIDTH{b_bit_i}};
        if (sgn_i) begin
            if (last_i) begin
                row_o[WIDTH-2:0] = ~row_o[WIDTH-2:0];
            end else begin
                row_o[WIDTH-1] = ~row_o[WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/bw_mult_seq.sv
// Sequential Baugh-Wooley multiplier: one partial-product row per cycle into a
// 2*WIDTH-bit accumulator, with valid/ready handshakes on both sides.
module bw_mult_seq
    import bw_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [PW-1:0]     acc_q, acc_d;

    logic                   last_row;
    logic                   b_bit;
    logic [WIDTH-1:0]       row;
    logic [PW-1:0]          row_shifted;
    logic [PW-1:0]          acc_sum;
    logic [2*MaxWidth-1:0]  const_wide;
    logic                   unused_const_hi;

    assign last_row = (cnt_q == CntW'(WIDTH - 1));
    assign b_bit    = b_q[cnt_q];

    bw_pp_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .a_i     (a_q),
        .b_bit_i (b_bit),
        .sgn_i   (sgn_q),
        .last_i  (last_row),
        .row_o   (row)
    );

    // Place the row at weight cnt_q and add; wraps modulo 2^(2*WIDTH).
    always_comb begin
        row_shifted = {{WIDTH{1'b0}}, row} << cnt_q;
        acc_sum     = acc_q + row_shifted;
    end

    // Constant term for the incoming operation, taken from the live sgn input.
    assign const_wide      = const_term(WIDTH, sgn);
    assign unused_const_hi = ^(const_wide >> PW);

    // Next-state, datapath loads and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = sgn;
                    acc_d   = const_wide[PW-1:0];
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                if (last_row) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                // Result leaves and a new operation may enter on the same edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        sgn_d   = sgn;
                        acc_d   = const_wide[PW-1:0];
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
        end
    end

    assign p = acc_q;

endmodule
